// File: rtl/icosoc_gpioseq_pkg.sv
// Shared definitions for the timed GPIO event sequencer: slave register map,
// CTRL/STATUS bit positions, GPIO target registers, FSM states, entry layout.
package icosoc_gpioseq_pkg;

    // Slave register map
    localparam logic [7:0] REG_STAGE  = 8'h00;
    localparam logic [7:0] REG_PUSH   = 8'h04;
    localparam logic [7:0] REG_CTRL   = 8'h08;
    localparam logic [7:0] REG_STATUS = 8'h0C;
    localparam logic [7:0] REG_DIR    = 8'h10;

    // Registers of the downstream GPIO module
    localparam logic [7:0] GPIO_REG_DATA = 8'h00;
    localparam logic [7:0] GPIO_REG_DIR  = 8'h04;

    // CTRL bit indices
    localparam int CTRL_RUN     = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CTRL_LOOP    = 2;
    localparam int CTRL_CLR_OVF = 3;

    // STATUS bit indices ([7:0] holds the FIFO count)
    localparam int STAT_EMPTY    = 16;
    localparam int STAT_FULL     = 17;
    localparam int STAT_OVF      = 18;
    localparam int STAT_BUSY     = 19;
    localparam int STAT_DIR_PEND = 20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ISSUE,
        ST_DIRW
    } seq_state_e;

    // Entry layout for the default build (IO_LENGTH=32, DELAY_W=24):
    // data in the upper field, delay in the lower field.
    typedef struct packed {
        logic [31:0] data;
        logic [23:0] delay;
    } seq_entry_t;

endpackage

// File: rtl/icosoc_gpioseq_fifo.sv
// Synchronous FIFO for sequencer entries. The caller only asserts push_i when
// there is room (a simultaneous pop counts as room); flush_i empties it and
// overrides push/pop in the same cycle.
module icosoc_gpioseq_fifo #(
    parameter int WIDTH = 56,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

    // Storage write; a full FIFO with pop+push rewrites the slot being popped,
    // which is safe because the popped value is taken before this edge.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk) begin
        if (!resetn || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/icosoc_mod_gpioseq.sv
// Timed GPIO event sequencer top: slave register decode, entry FIFO, timing
// FSM and the master port to the GPIO module. Define ICOSOC_GPIOSEQ_LOOP_EN
// to enable loop mode (popped entries are re-queued at the tail).
module icosoc_mod_gpioseq
    import icosoc_gpioseq_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ = 0,
    parameter int IO_LENGTH     = 32,
    parameter int DEPTH         = 16,
    parameter int DELAY_W       = 24
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ctrl_wr,
    input  logic        ctrl_rd,
    input  logic [7:0]  ctrl_addr,
    input  logic [31:0] ctrl_wdat,
    output logic [31:0] ctrl_rdat,
    output logic        ctrl_done,
    output logic        gpio_wr,
    output logic [7:0]  gpio_addr,
    output logic [31:0] gpio_wdat,
    input  logic        gpio_done
);
    localparam int EW = IO_LENGTH + DELAY_W;
    localparam int CW = $clog2(DEPTH + 1);
`ifdef ICOSOC_GPIOSEQ_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    // Clock frequency is part of the uniform module interface only.
    logic [31:0] cfg_unused;
    assign cfg_unused = 32'(CLOCK_FREQ_HZ);

    logic                 ctrl_done_q;
    logic [31:0]          ctrl_rdat_q;
    logic [IO_LENGTH-1:0] stage_q;
    logic [IO_LENGTH-1:0] dir_val_q;
    logic                 run_q, loop_q, ovf_q, dir_pend_q;
    seq_state_e           state_q;
    logic [DELAY_W-1:0]   cnt_q;
    logic [IO_LENGTH-1:0] data_q;
    logic                 gpio_wr_q;
    logic [7:0]           gpio_addr_q;
    logic [31:0]          gpio_wdat_q;

    logic                 req_acc, wr_acc, wr_stage, wr_push, wr_ctrl, wr_dir;
    logic                 flush_req, pop, repush, host_block, room;
    logic                 push_ok, push_drop, f_push;
    logic [EW-1:0]        f_wdata, f_rdata;
    logic [CW-1:0]        f_count;
    logic                 f_full, f_empty;
    logic [31:0]          status_w, rdat_d;

    assign ctrl_done = ctrl_done_q;
    assign ctrl_rdat = ctrl_rdat_q;
    assign gpio_wr   = gpio_wr_q;
    assign gpio_addr = gpio_addr_q;
    assign gpio_wdat = gpio_wdat_q;

    // Request decode, pop decision and FIFO push arbitration (loop re-push vs host).
    always_comb begin
        req_acc    = (ctrl_wr || ctrl_rd) && !ctrl_done_q;
        wr_acc     = ctrl_wr && !ctrl_done_q;
        wr_stage   = wr_acc && (ctrl_addr == REG_STAGE);
        wr_push    = wr_acc && (ctrl_addr == REG_PUSH);
        wr_ctrl    = wr_acc && (ctrl_addr == REG_CTRL);
        wr_dir     = wr_acc && (ctrl_addr == REG_DIR);
        flush_req  = wr_ctrl && ctrl_wdat[CTRL_FLUSH];
        pop        = (state_q == ST_IDLE) && !dir_pend_q && run_q && !f_empty && !flush_req;
        repush     = LOOP_EN && loop_q && pop;
        host_block = LOOP_EN && loop_q && run_q;
        room       = !f_full || pop;
        push_ok    = wr_push && !flush_req && room && !host_block;
        push_drop  = wr_push && !flush_req && (!room || host_block);
        f_push     = push_ok || repush;
        f_wdata    = repush ? f_rdata : {stage_q, ctrl_wdat[DELAY_W-1:0]};
    end

    // STATUS word and read-data mux; unmapped addresses read as zero.
    always_comb begin
        status_w                = '0;
        status_w[7:0]           = 8'(f_count);
        status_w[STAT_EMPTY]    = f_empty;
        status_w[STAT_FULL]     = f_full;
        status_w[STAT_OVF]      = ovf_q;
        status_w[STAT_BUSY]     = (state_q != ST_IDLE);
        status_w[STAT_DIR_PEND] = dir_pend_q;
        rdat_d                  = '0;
        case (ctrl_addr)
            REG_STAGE:  rdat_d = 32'(stage_q);
            REG_CTRL: begin
                rdat_d[CTRL_RUN]  = run_q;
                rdat_d[CTRL_LOOP] = loop_q;
            end
            REG_STATUS: rdat_d = status_w;
            default:    rdat_d = '0;
        endcase
    end

    icosoc_gpioseq_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (f_push),
        .pop_i   (pop),
        .flush_i (flush_req),
        .wdata_i (f_wdata),
        .rdata_o (f_rdata),
        .count_o (f_count),
        .full_o  (f_full),
        .empty_o (f_empty)
    );

    // Slave side: one-cycle completion pulse, register writes, overflow flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ctrl_done_q <= 1'b0;
            ctrl_rdat_q <= '0;
            stage_q     <= '0;
            run_q       <= 1'b0;
            loop_q      <= 1'b0;
            ovf_q       <= 1'b0;
            dir_val_q   <= '0;
        end else begin
            ctrl_done_q <= req_acc;
            if (req_acc && ctrl_rd) ctrl_rdat_q <= rdat_d;
            if (wr_stage) stage_q <= ctrl_wdat[IO_LENGTH-1:0];
            if (wr_ctrl) begin
                run_q  <= ctrl_wdat[CTRL_RUN];
                loop_q <= LOOP_EN && ctrl_wdat[CTRL_LOOP];
            end
            if (push_drop) begin
                ovf_q <= 1'b1;
            end else if (wr_ctrl && ctrl_wdat[CTRL_CLR_OVF]) begin
                ovf_q <= 1'b0;
            end
            if (wr_dir) dir_val_q <= ctrl_wdat[IO_LENGTH-1:0];
        end
    end

    // Sequencer FSM with registered master outputs; a pending direction write
    // takes priority over the next data pop. A new DIR write that lands as the
    // previous one completes keeps dir_pend set so the new value is issued too.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            dir_pend_q  <= 1'b0;
            gpio_wr_q   <= 1'b0;
            gpio_addr_q <= '0;
            gpio_wdat_q <= '0;
        end else begin
            if (wr_dir) begin
                dir_pend_q <= 1'b1;
            end else if (state_q == ST_DIRW && gpio_done) begin
                dir_pend_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (dir_pend_q) begin
                        gpio_wr_q   <= 1'b1;
                        gpio_addr_q <= GPIO_REG_DIR;
                        gpio_wdat_q <= 32'(dir_val_q);
                        state_q     <= ST_DIRW;
                    end else if (pop) begin
                        cnt_q   <= f_rdata[DELAY_W-1:0];
                        data_q  <= f_rdata[EW-1:DELAY_W];
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (flush_req) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == '0) begin
                        gpio_wr_q   <= 1'b1;
                        gpio_addr_q <= GPIO_REG_DATA;
                        gpio_wdat_q <= 32'(data_q);
                        state_q     <= ST_ISSUE;
                    end else begin
                        cnt_q <= cnt_q - DELAY_W'(1);
                    end
                end
                ST_ISSUE, ST_DIRW: begin
                    if (gpio_done) begin
                        gpio_wr_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icosoc_mod_gpioseq.sv
// Bench for the timed GPIO sequencer. Expected GPIO write streams come from a
// timing model: an idle decision point either issues a pending DIR write
// (next decision 2 cycles later) or pops an entry whose write rises 1+delay
// cycles later, with the next decision 2 cycles after that write rose.
module tb_icosoc_mod_gpioseq;
    import icosoc_gpioseq_pkg::*;

    logic        clk, resetn;
    logic        ctrl_wr, ctrl_rd;
    logic [7:0]  ctrl_addr;
    logic [31:0] ctrl_wdat, ctrl_rdat;
    logic        ctrl_done;
    logic        gpio_wr;
    logic [7:0]  gpio_addr;
    logic [31:0] gpio_wdat;
    logic        gpio_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_edge = 0;
    int dir_edge = -1;
    logic [31:0] dir_value = '0;
    bit done_en = 1'b1;
    logic wr_prev = 1'b0;
    logic [71:0] exp_q[$];   // {edge, addr, wdat}
    logic [71:0] act_q[$];
    logic [55:0] ent_q[$];   // {data, delay}

    icosoc_mod_gpioseq dut (
        .clk       (clk),
        .resetn    (resetn),
        .ctrl_wr   (ctrl_wr),
        .ctrl_rd   (ctrl_rd),
        .ctrl_addr (ctrl_addr),
        .ctrl_wdat (ctrl_wdat),
        .ctrl_rdat (ctrl_rdat),
        .ctrl_done (ctrl_done),
        .gpio_wr   (gpio_wr),
        .gpio_addr (gpio_addr),
        .gpio_wdat (gpio_wdat),
        .gpio_done (gpio_done)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // GPIO slave responder: one-cycle done pulse the cycle after a request
    initial begin
        gpio_done = 1'b0;
        forever begin
            @(negedge clk);
            gpio_done = done_en && gpio_wr && !gpio_done;
        end
    end

    // monitor: edge counter and log of each rising gpio_wr
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (gpio_wr && !wr_prev) act_q.push_back({32'(cyc), gpio_addr, gpio_wdat});
            wr_prev = gpio_wr;
        end
    end

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
        bit got;
        got = 1'b0;
        @(negedge clk);
        ctrl_wr = 1'b1; ctrl_addr = addr; ctrl_wdat = data;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            if (ctrl_done) begin got = 1'b1; last_edge = cyc; end
        end
        ctrl_wr = 1'b0;
        check("bus_wr_done", 72'(got), 72'(1));
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [31:0] data);
        bit got;
        got = 1'b0;
        data = '0;
        @(negedge clk);
        ctrl_rd = 1'b1; ctrl_addr = addr;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            if (ctrl_done) begin got = 1'b1; data = ctrl_rdat; end
        end
        ctrl_rd = 1'b0;
        check("bus_rd_done", 72'(got), 72'(1));
    endtask

    task automatic push_entry(input logic [31:0] data, input logic [23:0] delay);
        bus_write(REG_STAGE, data);
        bus_write(REG_PUSH, 32'(delay));
    endtask

    task automatic read_check(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        bus_read(addr, rd);
        check(tag, 72'(rd), 72'(exp));
    endtask

    // reference model: expected write stream from run edge a_edge
    task automatic build_model(input int a_edge, input int n_exp, input bit loop_mode);
        logic [55:0] q[$];
        logic [55:0] e;
        int t, w;
        bit dir_done;
        q = ent_q;
        exp_q.delete();
        t = a_edge + 1;
        dir_done = (dir_edge < 0);
        while (exp_q.size() < n_exp) begin
            if (!dir_done && dir_edge < t) begin
                exp_q.push_back({32'(t), 8'h04, dir_value});
                t = t + 2;
                dir_done = 1'b1;
            end else if (q.size() != 0) begin
                e = q.pop_front();
                if (loop_mode) q.push_back(e);
                w = t + 1 + int'(e[23:0]);
                exp_q.push_back({32'(w), 8'h00, e[55:24]});
                t = w + 2;
            end else if (!dir_done) begin
                t = dir_edge + 1;
            end else begin
                break;
            end
        end
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int i = 0; i < budget && act_q.size() < n; i++) @(posedge clk);
        repeat (8) @(posedge clk);
        #2;
    endtask

    // scoreboard comparison of logged writes against exp_q
    task automatic compare_writes(input string tag, input int n, input bit chk_size);
        if (chk_size) check({tag, "_nwr"}, 72'(act_q.size()), 72'(n));
        else          check({tag, "_enough"}, 72'(act_q.size() >= n), 72'(1));
        for (int i = 0; i < n && i < act_q.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), act_q[i], exp_q[i]);
    endtask

    initial begin
        logic [31:0] rd;
        logic [55:0] e;
        int a, n, w0;
        resetn = 1'b0; ctrl_wr = 1'b0; ctrl_rd = 1'b0; ctrl_addr = '0; ctrl_wdat = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gpio_wr", 72'(gpio_wr), 72'(0));
        check("rst_gpio_addr", 72'(gpio_addr), 72'(0));
        check("rst_gpio_wdat", 72'(gpio_wdat), 72'(0));
        check("rst_ctrl_done", 72'(ctrl_done), 72'(0));
        @(negedge clk);
        resetn = 1'b1;

        // done pulse drops the following cycle even with request held
        @(negedge clk);
        ctrl_rd = 1'b1; ctrl_addr = REG_STATUS;
        @(posedge clk); #1;
        check("pulse_done1", 72'(ctrl_done), 72'(1));
        check("pulse_rdat", 72'(ctrl_rdat), 72'(32'h10000));
        @(posedge clk); #1;
        check("pulse_done0", 72'(ctrl_done), 72'(0));
        ctrl_rd = 1'b0;
        read_check("rst_ctrl", REG_CTRL, 32'h0);
        read_check("unmapped_rd", 8'h40, 32'h0);
        bus_write(8'h44, 32'hDEAD);

        // directed: (0xA5,3),(0x5A,0)
        ent_q.delete();
        ent_q.push_back({32'hA5, 24'd3});
        ent_q.push_back({32'h5A, 24'd0});
        push_entry(32'hA5, 24'd3);
        push_entry(32'h5A, 24'd0);
        read_check("dir_cnt2", REG_STATUS, 32'h00002);
        act_q.delete();
        dir_edge = -1;
        bus_write(REG_CTRL, 32'h1);
        a = last_edge;
        build_model(a, 2, 1'b0);
        wait_writes(2, 100);
        compare_writes("basic", 2, 1'b1);
        if (act_q.size() >= 2) begin
            w0 = int'(act_q[0][71:40]);
            check("basic_pop_to_wr", 72'(w0 - a), 72'(5));
            check("basic_wr_gap", 72'(int'(act_q[1][71:40]) - w0), 72'(3));
        end
        read_check("basic_status", REG_STATUS, 32'h10000);
        bus_write(REG_CTRL, 32'h0);

        // randomized rounds with one DIR write dropped in at a random time
        for (int r = 0; r < 3; r++) begin
            bus_write(REG_CTRL, 32'h2);
            ent_q.delete();
            n = int'($urandom_range(3, 6));
            for (int i = 0; i < n; i++) begin
                e = {32'($urandom), 24'($urandom_range(0, 7))};
                ent_q.push_back(e);
                push_entry(e[55:24], e[23:0]);
            end
            act_q.delete();
            bus_write(REG_CTRL, 32'h1);
            a = last_edge;
            repeat ($urandom_range(0, 12)) @(posedge clk);
            dir_value = $urandom;
            bus_write(REG_DIR, dir_value);
            dir_edge = last_edge;
            build_model(a, n + 1, 1'b0);
            wait_writes(n + 1, 400);
            compare_writes($sformatf("rand%0d", r), n + 1, 1'b1);
            read_check("rand_status", REG_STATUS, 32'h10000);
            bus_write(REG_CTRL, 32'h0);
        end

        // DIR write during WAIT of a delay-10 entry
        bus_write(REG_CTRL, 32'h2);
        ent_q.delete();
        ent_q.push_back({32'h11, 24'd10});
        ent_q.push_back({32'h22, 24'd0});
        push_entry(32'h11, 24'd10);
        push_entry(32'h22, 24'd0);
        act_q.delete();
        bus_write(REG_CTRL, 32'h1);
        a = last_edge;
        repeat (2) @(posedge clk);
        dir_value = 32'hFF;
        bus_write(REG_DIR, 32'hFF);
        dir_edge = last_edge;
        build_model(a, 3, 1'b0);
        wait_writes(3, 200);
        compare_writes("dirw", 3, 1'b1);
        read_check("dirw_status", REG_STATUS, 32'h10000);
        dir_edge = -1;

        // run cleared mid-entry: current entry finishes, nothing else pops
        bus_write(REG_CTRL, 32'h2);
        push_entry(32'h44, 24'd5);
        push_entry(32'h55, 24'd0);
        act_q.delete();
        bus_write(REG_CTRL, 32'h1);
        bus_write(REG_CTRL, 32'h0);
        repeat (30) @(posedge clk);
        #2;
        check("runclr_nwr", 72'(act_q.size()), 72'(1));
        if (act_q.size() >= 1) check("runclr_data", 72'(act_q[0][31:0]), 72'(32'h44));
        read_check("runclr_status", REG_STATUS, 32'h00001);

        // flush during WAIT of a delay-100 entry
        bus_write(REG_CTRL, 32'h2);
        push_entry(32'h33, 24'd100);
        act_q.delete();
        bus_write(REG_CTRL, 32'h1);
        repeat (10) @(posedge clk);
        read_check("flush_busy", REG_STATUS, 32'h90000);
        bus_write(REG_CTRL, 32'h3);
        read_check("flush_status", REG_STATUS, 32'h10000);
        repeat (120) @(posedge clk);
        #2;
        check("flush_nwr", 72'(act_q.size()), 72'(0));
        bus_write(REG_CTRL, 32'h0);

        // fill to DEPTH, overflow on the extra push, then clr_ovf
        for (int i = 0; i < 16; i++) push_entry($urandom, 24'($urandom_range(0, 9)));
        read_check("fill_full", REG_STATUS, 32'h20010);
        push_entry(32'h99, 24'd1);
        read_check("fill_ovf", REG_STATUS, 32'h60010);
        bus_write(REG_CTRL, 32'h8);
        read_check("fill_clr_ovf", REG_STATUS, 32'h20010);
        read_check("fill_ctrl", REG_CTRL, 32'h0);
        bus_write(REG_CTRL, 32'h2);
        read_check("fill_flushed", REG_STATUS, 32'h10000);

`ifdef ICOSOC_GPIOSEQ_LOOP_EN
        // loop mode: three entries repeat, count stays 3, host push rejected
        ent_q.delete();
        for (int i = 0; i < 3; i++) begin
            e = {32'($urandom), 24'($urandom_range(0, 3))};
            ent_q.push_back(e);
            push_entry(e[55:24], e[23:0]);
        end
        act_q.delete();
        dir_edge = -1;
        bus_write(REG_CTRL, 32'h5);
        a = last_edge;
        build_model(a, 9, 1'b1);
        wait_writes(9, 300);
        compare_writes("loop", 9, 1'b0);
        bus_read(REG_STATUS, rd);
        check("loop_count", 72'(rd[7:0]), 72'(3));
        push_entry(32'h66, 24'd0);
        bus_read(REG_STATUS, rd);
        check("loop_ovf", 72'(rd[STAT_OVF]), 72'(1));
        check("loop_count2", 72'(rd[7:0]), 72'(3));
        read_check("loop_ctrl", REG_CTRL, 32'h5);
        bus_write(REG_CTRL, 32'hA);
        repeat (20) @(posedge clk);
        read_check("loop_end", REG_STATUS, 32'h10000);
`else
        bus_write(REG_CTRL, 32'h4);
        read_check("noloop_ctrl", REG_CTRL, 32'h0);
        bus_write(REG_CTRL, 32'h0);
`endif

        // reset while a GPIO write is outstanding
        bus_write(REG_CTRL, 32'h2);
        push_entry(32'h77, 24'd0);
        done_en = 1'b0;
        bus_write(REG_CTRL, 32'h1);
        for (int i = 0; i < 20 && !gpio_wr; i++) begin
            @(posedge clk); #1;
        end
        check("rstmid_wr_hi", 72'(gpio_wr), 72'(1));
        check("rstmid_wdat", 72'(gpio_wdat), 72'(32'h77));
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("rstmid_wr_lo", 72'(gpio_wr), 72'(0));
        check("rstmid_addr", 72'(gpio_addr), 72'(0));
        @(negedge clk);
        resetn = 1'b1;
        done_en = 1'b1;
        read_check("rstmid_status", REG_STATUS, 32'h10000);
        read_check("rstmid_ctrl", REG_CTRL, 32'h0);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
